// File: rtl/expr_paren_if.sv
// Character stream in, expression status out, for the
// parenthesised-expression checker.
interface expr_paren_if #(
  parameter int unsigned MAX_DEPTH = 7,
  parameter int unsigned CNT_W     = 8
);
  localparam int unsigned DW = $clog2(MAX_DEPTH + 1);

  logic             in_valid;
  logic [7:0]       in;
  logic             out;
  logic             err;
  logic [DW-1:0]    depth;
  logic [CNT_W-1:0] cnt;

  modport master (
    output in_valid, in,
    input  out, err, depth, cnt
  );

  modport slave (
    input  in_valid, in,
    output out, err, depth, cnt
  );
endinterface

// File: rtl/expr_paren.sv
// Streaming syntax checker for digit / operator / paren
// expressions, one ASCII character per valid cycle.
module expr_paren #(
  parameter int unsigned MAX_DEPTH  = 7,
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned EXT_OPS    = 0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic          clk,
  input  logic          clr,
  expr_paren_if.slave   bus
);
  localparam int unsigned DW = $clog2(MAX_DEPTH + 1);
  localparam int unsigned NW = $clog2(MAX_DIGITS + 1);

  localparam logic [DW-1:0] DMAX = DW'(MAX_DEPTH);
  localparam logic [NW-1:0] NMAX = NW'(MAX_DIGITS);
  localparam logic [DW-1:0] D1   = DW'(1);
  localparam logic [NW-1:0] N1   = NW'(1);

  typedef enum logic [5:0] {
    START = 6'b000001,
    NUM   = 6'b000010,
    OP    = 6'b000100,
    LP    = 6'b001000,
    RP    = 6'b010000,
    ERR   = 6'b100000
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic [NW-1:0]    dcnt_q,  dcnt_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic is_dig, is_op, is_lp, is_rp;
  logic ext;

  always_comb begin
    ext    = (EXT_OPS != 0);
    is_dig = (bus.in >= 8'd48) && (bus.in <= 8'd57);
    is_op  = (bus.in == 8'd43) || (bus.in == 8'd42) ||
             (ext && ((bus.in == 8'd45) ||
                      (bus.in == 8'd47)));
    is_lp  = (bus.in == 8'd40);
    is_rp  = (bus.in == 8'd41);
  end

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      START, OP, LP: if (bus.in_valid) begin
        if (is_dig) begin
          state_d = NUM;
          dcnt_d  = N1;
        end else if (is_lp && depth_q != DMAX) begin
          state_d = LP;
          depth_d = depth_q + D1;
        end else begin
          state_d = ERR;
        end
      end
      NUM: if (bus.in_valid) begin
        dcnt_d = '0;
        if (is_dig && dcnt_q != NMAX) begin
          state_d = NUM;
          dcnt_d  = dcnt_q + N1;
        end else if (is_op) begin
          state_d = OP;
        end else if (is_rp && depth_q != '0) begin
          state_d = RP;
          depth_d = depth_q - D1;
        end else begin
          state_d = ERR;
        end
      end
      RP: if (bus.in_valid) begin
        if (is_op) begin
          state_d = OP;
        end else if (is_rp && depth_q != '0) begin
          state_d = RP;
          depth_d = depth_q - D1;
        end else begin
          state_d = ERR;
        end
      end
      ERR: ;
      // Corrupted one-hot encoding recovers immediately.
      default: state_d = START;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.in_valid && state_q != ERR && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= START;
      depth_q <= '0;
      dcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      dcnt_q  <= dcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out   = (state_q == NUM || state_q == RP) &&
                     (depth_q == '0);
  assign bus.err   = (state_q == ERR);
  assign bus.depth = depth_q;
  assign bus.cnt   = cnt_q;
endmodule

// File: tb/tb_expr_paren.sv
// Directed checks for expr_paren: default build plus a
// shallow / extended-op / narrow-counter build.
module tb_expr_paren;
  logic clk = 1'b0;
  logic clr = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  expr_paren_if #(.MAX_DEPTH(7), .CNT_W(8)) b0 ();
  expr_paren_if #(.MAX_DEPTH(2), .CNT_W(3)) b1 ();

  expr_paren #(
    .MAX_DEPTH(7), .MAX_DIGITS(4),
    .EXT_OPS(0), .CNT_W(8)
  ) dut0 (.clk(clk), .clr(clr), .bus(b0));

  expr_paren #(
    .MAX_DEPTH(2), .MAX_DIGITS(4),
    .EXT_OPS(1), .CNT_W(3)
  ) dut1 (.clk(clk), .clr(clr), .bus(b1));

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic send(input byte c);
    @(negedge clk);
    b0.in_valid = 1'b1; b0.in = c;
    b1.in_valid = 1'b1; b1.in = c;
    @(posedge clk);
    #1;
    b0.in_valid = 1'b0;
    b1.in_valid = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
  endtask

  string s;
  logic [31:0] e_out [9];
  logic [31:0] e_dep [9];

  initial begin
    b0.in_valid = 1'b0; b0.in = 8'd0;
    b1.in_valid = 1'b0; b1.in = 8'd0;
    #12;
    chk("rst_out",   b0.out,   0);
    chk("rst_err",   b0.err,   0);
    chk("rst_depth", b0.depth, 0);
    chk("rst_cnt",   b0.cnt,   0);
    @(negedge clk);
    clr = 1'b1;

    // basic stream
    s = "12+3*45";
    e_out[0:6] = '{1, 1, 0, 1, 0, 1, 1};
    for (int i = 0; i < 7; i++) begin
      send(s[i]);
      chk($sformatf("s1_out%0d", i), b0.out, e_out[i]);
      chk($sformatf("s1_err%0d", i), b0.err, 0);
    end
    chk("s1_cnt", b0.cnt, 7);

    // nesting
    do_reset();
    s = "(1+(2))*3";
    e_dep = '{1, 1, 1, 2, 2, 1, 0, 0, 0};
    e_out = '{0, 0, 0, 0, 0, 0, 1, 0, 1};
    for (int i = 0; i < 9; i++) begin
      send(s[i]);
      chk($sformatf("s2_dep%0d", i), b0.depth, e_dep[i]);
      chk($sformatf("s2_out%0d", i), b0.out, e_out[i]);
    end
    chk("s2_err", b0.err, 0);

    // depth overflow on shallow build
    do_reset();
    s = "(((";
    for (int i = 0; i < 3; i++) begin
      send(s[i]);
      chk($sformatf("s3_err%0d", i), b1.err, i == 2);
    end
    chk("s3_cnt", b1.cnt, 3);
    chk("s3_dep", b1.depth, 2);

    // digit overflow, then ERR absorbs
    do_reset();
    s = "12345";
    for (int i = 0; i < 5; i++) begin
      send(s[i]);
      chk($sformatf("s4_out%0d", i), b0.out, i < 4);
      chk($sformatf("s4_err%0d", i), b0.err, i == 4);
    end
    send("1");
    chk("s4_hold_err", b0.err, 1);
    chk("s4_hold_cnt", b0.cnt, 5);

    // '-' is illegal without EXT_OPS, legal with it
    do_reset();
    s = "1-2";
    for (int i = 0; i < 3; i++) send(s[i]);
    chk("s5_err0", b0.err, 1);
    chk("s5_cnt0", b0.cnt, 2);
    chk("s5_out1", b1.out, 1);
    chk("s5_err1", b1.err, 0);

    // empty parens and leading op
    do_reset();
    send("(");
    send(")");
    chk("s6_empty_err", b0.err, 1);
    chk("s6_empty_dep", b0.depth, 1);
    do_reset();
    send("+");
    chk("s6_lead_err", b0.err, 1);
    chk("s6_lead_cnt", b0.cnt, 1);

    // unmatched ')' at depth 0
    do_reset();
    send("5");
    send(")");
    chk("s7_rp_err", b0.err, 1);

    // counter saturation on 3-bit build
    do_reset();
    s = "1+1+1+1+1";
    for (int i = 0; i < 9; i++) send(s[i]);
    chk("s8_sat_cnt", b1.cnt, 7);
    chk("s8_sat_out", b1.out, 1);
    chk("s8_sat_err", b1.err, 0);

    // hold on idle cycle, async clear mid-cycle
    do_reset();
    send("(");
    @(negedge clk);
    b0.in = "1"; b1.in = "1";
    @(posedge clk);
    #1;
    chk("s9_idle_dep", b0.depth, 1);
    chk("s9_idle_cnt", b0.cnt, 1);
    send("1");
    chk("s9_dep", b0.depth, 1);
    chk("s9_cnt", b0.cnt, 2);
    chk("s9_out", b0.out, 0);
    #2;
    clr = 1'b0;
    #1;
    chk("s9_clr_dep", b0.depth, 0);
    chk("s9_clr_cnt", b0.cnt, 0);
    chk("s9_clr_out", b0.out, 0);
    @(negedge clk);
    b0.in_valid = 1'b1; b0.in = "5";
    @(posedge clk);
    #1;
    chk("s9_clr_hold", b0.cnt, 0);
    b0.in_valid = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    send("7");
    chk("s9_new_out", b0.out, 1);
    chk("s9_new_cnt", b0.cnt, 1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
